// File: rtl/div_clk_checker.sv
// div_clk_checker
//    Receive-side checker for a divided clock. clk_in is sampled in the i_clk
//    domain. The checker measures the clk_in period (rising to rising) and its
//    high time (rising to falling) in i_clk cycles. The period is compared
//    with EXP_DIV to report lock, error pulses and a saturating error count.
//
//    Optional feature: define DIV_CLK_CHECKER_SYNC_EN to put a 2-flop
//    synchronizer in front of the sampler. clk_in may then come from an
//    unrelated clock, and the latency grows by two i_clk edges.
//
// Ports
//    i_clk          fast reference clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_clk_in       divided clock under check
//    o_period       last measured period (i_clk cycles)
//    o_high_time    last measured high phase (i_clk cycles)
//    o_period_vld   one-cycle pulse when o_period is updated
//    o_locked       LOCK_CNT consecutive periods equal to EXP_DIV
//    o_err          one-cycle pulse on period mismatch or timeout
//    o_err_cnt      saturating count of o_err pulses
//
// FSM states
//    state   | meaning
//    ST_IDLE | not armed; the next rise only starts a measurement
//    ST_ACQ  | measuring, not yet LOCK_CNT good periods in a row
//    ST_LOCK | LOCK_CNT or more good periods in a row

module div_clk_checker #(
    parameter int EXP_DIV  = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_in,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic             o_period_vld,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int               GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_DIV);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    logic              w_clk_smp;
    logic              r_s;
    logic              r_s_d;
    logic              r_rise;
    logic              r_fall;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [GOOD_W-1:0] r_good;
    state_t            r_state;

`ifdef DIV_CLK_CHECKER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_clk_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_clk_smp = r_sync2;
`else
    assign w_clk_smp = i_clk_in;
`endif

    // Edge detection is registered. All counters and the FSM then act on
    // single-cycle pulses that come from flops only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s    <= w_clk_smp;
            r_s_d  <= r_s;
            r_rise <= r_s & ~r_s_d;
            r_fall <= ~r_s & r_s_d;
        end
    end

    // r_s_d is the sampled level aligned with the r_rise/r_fall pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            if (r_rise) begin
                r_per_cnt <= CNT_W'(1);
            end else if (r_per_cnt != CNT_MAX) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end

            if (r_rise) begin
                r_hi_cnt <= CNT_W'(1);
            end else if (r_s_d && (r_hi_cnt != CNT_MAX)) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_good       <= '0;
            o_period     <= '0;
            o_high_time  <= '0;
            o_period_vld <= 1'b0;
            o_locked     <= 1'b0;
            o_err        <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            o_period_vld <= 1'b0;
            o_err        <= 1'b0;

            if (r_fall && (r_state != ST_IDLE)) begin
                o_high_time <= r_hi_cnt;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_rise) begin
                        r_state <= ST_ACQ;
                    end
                end
                default: begin
                    // A rise takes priority over the timeout. A saturated
                    // count seen together with a rise is a bad period.
                    if (r_rise) begin
                        o_period     <= r_per_cnt;
                        o_period_vld <= 1'b1;
                        if (r_per_cnt == EXP_V) begin
                            if (r_good >= (LOCK_V - 1'b1)) begin
                                r_good   <= LOCK_V;
                                r_state  <= ST_LOCK;
                                o_locked <= 1'b1;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end else begin
                            o_err    <= 1'b1;
                            r_good   <= '0;
                            o_locked <= 1'b0;
                            r_state  <= ST_ACQ;
                            if (o_err_cnt != CNT_MAX) begin
                                o_err_cnt <= o_err_cnt + 1'b1;
                            end
                        end
                    end else if (r_per_cnt == CNT_MAX) begin
                        // Dropping to IDLE makes the timeout fire only once
                        // and makes the next rise re-arm without measuring.
                        o_err    <= 1'b1;
                        r_good   <= '0;
                        o_locked <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (o_err_cnt != CNT_MAX) begin
                            o_err_cnt <= o_err_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/div_clk_checker.md
Name: div_clk_checker

Overview:
Receive-side companion to the team's clock dividers. It samples a divided clock (clk_in) in the fast clk domain and measures its period and high time in clk cycles. It compares the period against the expected division ratio and reports lock, error and an error count. It sits next to each divider instance, as a built-in self-check and as a monitor in benches.

Parameters:
EXP_DIV, 4, expected clk_in period in clk cycles (>=2)
CNT_W, 8, width of measurement counters and error counter
LOCK_CNT, 4, consecutive correct periods required to assert locked (>=1)

Ports:
clk  input  1  fast reference clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
clk_in  input  1  divided clock under check, generated from clk
period  output  CNT_W  last measured period, clk cycles rising-to-rising
high_time  output  CNT_W  last measured high phase, clk cycles rising-to-falling
period_vld  output  1  one-cycle pulse when period is updated
locked  output  1  LOCK_CNT consecutive periods equal to EXP_DIV
err  output  1  one-cycle pulse on mismatch or timeout
err_cnt  output  CNT_W  saturating count of err pulses

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, all internal counters 0, sample flops 0.
- Sampling:
  - s = registered clk_in; s_d = registered s.
  - rise = s & ~s_d; fall = ~s & s_d.
  - All detections are made on these registered samples.
- per_cnt:
  - On rise: per_cnt <= 1.
  - Otherwise: increments each cycle, saturating at 2^CNT_W-1.
- hi_cnt:
  - On rise: hi_cnt <= 1.
  - Otherwise, while s=1: increments, saturating.
  - On fall: high_time <= hi_cnt.
- FSM states IDLE, ACQ, LOCK:
  - IDLE: per_cnt ignored. First rise moves to ACQ; no measurement is published.
  - ACQ/LOCK, on rise:
    - period <= per_cnt; period_vld=1 next cycle (registered; one cycle after the rise-detect edge).
    - If per_cnt==EXP_DIV: good_cnt increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, go to LOCK with locked=1, asserted in the same cycle as period_vld.
    - If per_cnt!=EXP_DIV: err pulse with period_vld, good_cnt <= 0, locked <= 0, state ACQ.
  - ACQ/LOCK, timeout: per_cnt reaches 2^CNT_W-1 with no rise. Err pulse once, locked <= 0, good_cnt <= 0, state IDLE, no period_vld.
- err_cnt:
  - Increments on every err pulse; saturates at 2^CNT_W-1, never wraps.
  - Cleared only by reset.
- Simultaneous events:
  - Rise and per_cnt saturation in the same cycle: the rise wins and is treated as a mismatch (period=2^CNT_W-1, err, ACQ), not a timeout.
  - Only one err pulse per cycle.
- Reset mid-operation: immediate return to reset values; the first rise after release only re-arms.
- End-to-end latency, clk_in rising to period_vld: 3 clk edges (sample, edge register, output register).

Optional Feature:
Macro DIV_CLK_CHECKER_SYNC_EN.
- Defined: clk_in passes through a 2-flop synchronizer before s, so clk_in may come from an unrelated clock. Latency rises to 5 edges. Measured values are unchanged for stable input.
- Undefined: clk_in is sampled directly. clk_in must then be generated synchronously from clk.

Test Plan:
1. reset=0 for 17 cycles, then 1; clk_in = divide-by-4 of clk -> period_vld every 4 cycles with period=4, high_time=2. locked=1 with the 4th valid measurement (5th rise). err=0, err_cnt=0.
2. After lock, switch clk_in to divide-by-6 -> next period_vld shows period=6 with err=1 for one cycle. locked falls to 0, err_cnt=1, and err_cnt increments once per further period.
3. Return to divide-by-4 after test 2 -> locked reasserts exactly 4 valid periods later; err_cnt holds its value.
4. While locked, hold clk_in=0 -> exactly one err pulse when per_cnt hits 255, locked=0, no period_vld. The next rise produces no measurement; measurements resume on the rise after that.
5. Pulse reset low for 5 cycles while locked -> period, high_time, locked, err_cnt all 0 within that cycle (asynchronous). Relock takes the same count as test 1.
6. Feed 300 divide-by-5 periods -> err_cnt saturates at 255 and stays. Repeat test 1 with DIV_CLK_CHECKER_SYNC_EN defined -> identical values, each period_vld 2 cycles later.
